// File: rtl/tdoa_pkg.sv
// tdoa_pkg: shared state encoding and width/sector helpers for the TDOA SAD estimator
package tdoa_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, SEARCH, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lag_sector(input int k, input int l, input int led_w);
    return k * led_w / l;
  endfunction
endpackage

// File: rtl/tdoa_sample_buffer.sv
// tdoa_sample_buffer: two-channel sample store, one shared write port, one async read per channel
module tdoa_sample_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata_l,
  input  logic [DATA_WIDTH-1:0] wdata_r,
  input  logic [AW-1:0]         raddr_l,
  input  logic [AW-1:0]         raddr_r,
  output logic [DATA_WIDTH-1:0] rdata_l,
  output logic [DATA_WIDTH-1:0] rdata_r
);
  logic [DATA_WIDTH-1:0] mem_l [DEPTH];
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  always_ff @(posedge clk)
    if (we) begin
      mem_l[waddr] <= wdata_l;
      mem_r[waddr] <= wdata_r;
    end
  assign rdata_l = mem_l[raddr_l];
  assign rdata_r = mem_r[raddr_r];
endmodule

// File: rtl/tdoa_sad_estimator.sv
// tdoa_sad_estimator: captures a stereo window and picks the lag with minimum sum of absolute differences
module tdoa_sad_estimator
  import tdoa_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WIN = 32,
  parameter int MAX_LAG = 16,
  parameter int LED_W = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    in_valid,
  input  logic [DATA_WIDTH-1:0]                   left_in,
  input  logic [DATA_WIDTH-1:0]                   right_in,
  output logic                                    busy,
  output logic                                    result_valid,
  output logic signed [clog2(MAX_LAG+1):0]        best_lag,
  output logic [DATA_WIDTH+clog2(WIN):0]          best_sad,
  output logic [LED_W-1:0]                        led_pattern
);
  localparam int N  = WIN + 2*MAX_LAG;
  localparam int L  = 2*MAX_LAG + 1;
  localparam int AW = clog2(N);
  localparam int JW = clog2(WIN);
  localparam int KW = clog2(L) > 0 ? clog2(L) : 1;
  localparam int LW = clog2(MAX_LAG+1) + 1;
  localparam int SW = DATA_WIDTH + 1 + clog2(WIN);
  state_t state_q, state_d;
  logic [AW-1:0] n;
  logic [JW-1:0] j;
  logic [KW-1:0] k, kmin, k_best;
  logic [SW-1:0] acc, min_sad, sad_now, sad_best;
  logic signed [DATA_WIDTH-1:0] l_rd, r_rd;
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0] mag;
  logic accept, last_j, last_k, better;
  tdoa_sample_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(N), .AW(AW)) u_buf (
    .clk(clk),
    .we(accept),
    .waddr(n),
    .wdata_l(left_in),
    .wdata_r(right_in),
    .raddr_l(AW'(MAX_LAG) + AW'(j)),
    .raddr_r(AW'(k) + AW'(j)),
    .rdata_l(l_rd),
    .rdata_r(r_rd)
  );
  assign accept   = state_q == CAPTURE && in_valid;
  assign last_j   = j == JW'(WIN-1);
  assign last_k   = k == KW'(L-1);
  assign diff     = (DATA_WIDTH+1)'(l_rd) - (DATA_WIDTH+1)'(r_rd);
  assign mag      = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign sad_now  = acc + SW'(mag);
  assign better   = sad_now < min_sad;
  assign k_best   = better ? k : kmin;
  assign sad_best = better ? sad_now : min_sad;
  always_comb begin
    state_d = state_q == IDLE    ? (start ? CAPTURE : IDLE) :
              state_q == CAPTURE ? (accept && n == AW'(N-1) ? SEARCH : CAPTURE) :
              state_q == SEARCH  ? (last_j && last_k ? DONE : SEARCH) : IDLE;
    busy = state_q == CAPTURE || state_q == SEARCH;
    result_valid = state_q == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n <= '0;
      j <= '0;
      k <= '0;
      kmin <= '0;
      acc <= '0;
      min_sad <= '0;
      best_lag <= '0;
      best_sad <= '0;
      led_pattern <= LED_W'(1) << (LED_W/2);
    end else begin
      if (state_q == IDLE && start) n <= '0;
      if (accept) n <= n + AW'(1);
      if (state_q == CAPTURE && state_d == SEARCH) begin
        j <= '0;
        k <= '0;
        kmin <= '0;
        acc <= '0;
        min_sad <= '1;
      end
      if (state_q == SEARCH) begin
        j <= last_j ? '0 : j + JW'(1);
        acc <= last_j ? '0 : sad_now;
        if (last_j) begin
          k <= k + KW'(1);
          kmin <= k_best;
          min_sad <= sad_best;
        end
        if (last_j && last_k) begin
          best_lag <= LW'(int'(k_best) - MAX_LAG);
          best_sad <= sad_best;
          led_pattern <= LED_W'(1) << lag_sector(int'(k_best), L, LED_W);
        end
      end
    end
  end
endmodule
